// File: rtl/pmci_spi_cmd_seq_pkg.sv
// ---- pmci_spi_seq_pkg : offsets, bit positions and enums for the SPI command sequencer (rev 1.0) ----
`default_nettype none

package pmci_spi_seq_pkg;

  localparam logic [1:0] SPI_CSR_OFS   = 2'd0;
  localparam logic [1:0] SPI_AR_OFS    = 2'd1;
  localparam logic [1:0] SPI_RD_DR_OFS = 2'd2;
  localparam logic [1:0] SPI_WR_DR_OFS = 2'd3;

  localparam int CMD_LSB  = 0;
  localparam int CMD_MSB  = 1;
  localparam int BUSY_BIT = 2;
  localparam int TOUT_BIT = 3;
  localparam int OVR_BIT  = 4;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_RSVD  = 2'd3
  } t_cmd;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_REQ  = 2'd1,
    S_RD_REQ  = 2'd2,
    S_RD_WAIT = 2'd3
  } t_seq_state;

  function automatic logic [31:0] csr_pack(input t_cmd cmd, input logic busy,
                                           input logic tout, input logic ovr);
    logic [31:0] v;
    v                  = '0;
    v[CMD_MSB:CMD_LSB] = cmd;
    v[BUSY_BIT]        = busy;
    v[TOUT_BIT]        = tout;
    v[OVR_BIT]         = ovr;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pmci_spi_seq_timer.sv
// ---- pmci_spi_seq_timer : saturating transaction cycle counter with expiry flag (rev 1.0) ----
`default_nettype none

module pmci_spi_seq_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LIM = CW'(LIMIT);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && (cnt != LIM)) begin
          cnt <= cnt + CW'(1);
        end
      end

      // Flags the cycle whose increment brings the count to LIMIT, so a
      // transaction is allowed exactly LIMIT busy cycles.
      assign expired = en && (cnt >= (LIM - CW'(1)));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pmci_spi_cmd_seq.sv
// ---- pmci_spi_cmd_seq : CSR-programmed single-transaction Avalon-MM command sequencer (rev 1.0) ----
`default_nettype none

module pmci_spi_cmd_seq
  import pmci_spi_seq_pkg::*;
#(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          csr_wr,
  input  logic          csr_rd,
  input  logic [1:0]    csr_addr,
  input  logic [31:0]   csr_wdata,
  output logic [31:0]   csr_rdata,
  output logic          csr_rdvalid,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  output logic          avm_write,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  input  logic          avm_readdatavalid,
  input  logic          avm_waitrequest
);

  t_seq_state    state;
  t_cmd          act_cmd;
  logic [AW-1:0] spi_ar;
  logic [31:0]   wr_dr;
  logic [31:0]   rd_dr;
  logic          tout_err;
  logic          ovr_err;

  logic          busy;
  logic          wr_csr, wr_ar, wr_wdr;
  t_cmd          wcmd;
  logic          cmd_go;
  logic          ovr_hit;
  logic          csr_taken;
  logic          expired;
  logic          tout_fire;
  logic [31:0]   rd_mux;

  assign busy   = (state != S_IDLE);
  assign wr_csr = csr_wr && (csr_addr == SPI_CSR_OFS);
  assign wr_ar  = csr_wr && (csr_addr == SPI_AR_OFS);
  assign wr_wdr = csr_wr && (csr_addr == SPI_WR_DR_OFS);
  assign wcmd   = t_cmd'(csr_wdata[CMD_MSB:CMD_LSB]);
  assign cmd_go = wr_csr && ((wcmd == CMD_WRITE) || (wcmd == CMD_READ));

  // A command while busy is dropped whole, W1C bits included.
  assign ovr_hit   = busy && (wr_ar || wr_wdr || cmd_go);
  assign csr_taken = wr_csr && !(busy && cmd_go);

  pmci_spi_seq_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!busy),
    .en      (busy),
    .expired (expired)
  );

  // Completion in the same cycle as expiry takes priority over the abort.
  always_comb begin
    tout_fire = 1'b0;
    case (state)
      S_WR_REQ, S_RD_REQ: tout_fire = expired && avm_waitrequest;
      S_RD_WAIT:          tout_fire = expired && !avm_readdatavalid;
      default:            tout_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      act_cmd       <= CMD_NONE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      rd_dr         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_go) begin
            avm_address   <= spi_ar;
            avm_writedata <= wr_dr;
            act_cmd       <= wcmd;
            if (wcmd == CMD_WRITE) begin
              state     <= S_WR_REQ;
              avm_write <= 1'b1;
            end else begin
              state    <= S_RD_REQ;
              avm_read <= 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          if (!avm_waitrequest || tout_fire) begin
            avm_write <= 1'b0;
            act_cmd   <= CMD_NONE;
            state     <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_RD_WAIT;
          end else if (tout_fire) begin
            avm_read <= 1'b0;
            act_cmd  <= CMD_NONE;
            state    <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            rd_dr   <= avm_readdata;
            act_cmd <= CMD_NONE;
            state   <= S_IDLE;
          end else if (tout_fire) begin
            act_cmd <= CMD_NONE;
            state   <= S_IDLE;
          end
        end
        default: begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          act_cmd   <= CMD_NONE;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_ar   <= '0;
      wr_dr    <= '0;
      tout_err <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      if (wr_ar && !busy) begin
        spi_ar <= csr_wdata[AW-1:0];
      end
      if (wr_wdr && !busy) begin
        wr_dr <= csr_wdata;
      end
      tout_err <= tout_fire | (tout_err & ~(csr_taken & csr_wdata[TOUT_BIT]));
      ovr_err  <= ovr_hit   | (ovr_err  & ~(csr_taken & csr_wdata[OVR_BIT]));
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      SPI_CSR_OFS:   rd_mux = csr_pack(act_cmd, busy, tout_err, ovr_err);
      SPI_AR_OFS:    rd_mux = 32'(spi_ar);
      SPI_RD_DR_OFS: rd_mux = rd_dr;
      SPI_WR_DR_OFS: rd_mux = wr_dr;
      default:       rd_mux = '0;
    endcase
  end

  // Registered read path: the response reflects register state before any
  // write landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdvalid <= 1'b0;
      csr_rdata   <= '0;
    end else begin
      csr_rdvalid <= csr_rd;
      if (csr_rd) begin
        csr_rdata <= rd_mux;
      end
    end
  end

endmodule

`default_nettype wire
